// File: rtl/sb_debug_target.sv
// System-bus responder hosting a word-addressed scratchpad for exercising bus masters.
// Serves single/burst reads and writes; all outputs are registered and zero when idle.
//
// state   | meaning
// S_IDLE  | waiting for a request cycle that hits the region
// S_WRITE | accepting write beats into the scratchpad
// S_READ  | presenting read beats, holding while the master is busy
// S_END   | one-cycle end-of-read pulse
// S_ERROR | one-cycle error + end pulse for a bad request
module sb_debug_target #(
  parameter logic [31:0] BASE_ADDRESS = 32'h5000_0000,
  parameter int          DEPTH_LOG2   = 4
) (
  input  logic        sb_clock_i,
  input  logic        sb_reset_i,
  input  logic        sb_begin_transaction_i,
  input  logic [31:0] sb_address_data_i,
  input  logic [3:0]  sb_byte_enables_i,
  input  logic [7:0]  sb_burst_size_i,
  input  logic        sb_read_n_write_i,
  input  logic        sb_data_valid_i,
  input  logic        sb_end_transaction_i,
  input  logic        sb_busy_i,
  output logic [31:0] sb_address_data_o,
  output logic        sb_data_valid_o,
  output logic        sb_end_transaction_o,
  output logic        sb_error_o,
  output logic        sb_busy_o
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam int TOP   = DEPTH_LOG2 + 2;
  localparam int SPANW = DEPTH_LOG2 + 9;

  typedef enum logic [2:0] {S_IDLE, S_WRITE, S_READ, S_END, S_ERROR} state_t;

  state_t                r_state, w_state_nxt;
  logic [DEPTH_LOG2-1:0] r_index, w_index_nxt;
  logic [7:0]            r_remaining, w_remaining_nxt;
  logic [3:0]            r_be, w_be_nxt;
  logic [31:0]           r_rdata;
  logic                  r_valid, r_end, r_error;
  logic                  w_valid_nxt, w_end_nxt, w_error_nxt;
  logic                  w_load_rdata, w_mem_we;
  logic                  w_hit, w_misaligned, w_overflow;
  logic [SPANW-1:0]      w_span;
  logic [31:0]           r_mem [DEPTH];

  assign w_hit        = sb_begin_transaction_i &&
                        (sb_address_data_i[31:TOP] == BASE_ADDRESS[31:TOP]);
  assign w_misaligned = (sb_address_data_i[1:0] != 2'b00);
  // Wide enough that start + burst + 1 never wraps before the compare.
  assign w_span       = SPANW'(sb_address_data_i[TOP-1:2]) + SPANW'(sb_burst_size_i) + SPANW'(1);
  assign w_overflow   = (w_span > SPANW'(DEPTH));

  always_comb begin
    w_state_nxt     = r_state;
    w_index_nxt     = r_index;
    w_remaining_nxt = r_remaining;
    w_be_nxt        = r_be;
    w_valid_nxt     = 1'b0;
    w_end_nxt       = 1'b0;
    w_error_nxt     = 1'b0;
    w_load_rdata    = 1'b0;
    w_mem_we        = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_hit) begin
          if (w_misaligned || w_overflow) begin
            w_state_nxt = S_ERROR;
            w_end_nxt   = 1'b1;
            w_error_nxt = 1'b1;
          end else begin
            w_index_nxt     = sb_address_data_i[TOP-1:2];
            w_remaining_nxt = sb_burst_size_i;
            w_be_nxt        = sb_byte_enables_i;
            if (sb_read_n_write_i) begin
              w_state_nxt  = S_READ;
              w_valid_nxt  = 1'b1;
              w_load_rdata = 1'b1;
            end else begin
              w_state_nxt = S_WRITE;
            end
          end
        end
      end
      S_WRITE: begin
        if (sb_end_transaction_i) begin
          w_state_nxt = S_IDLE;
        end else if (sb_data_valid_i) begin
          w_mem_we = 1'b1;
          if (r_remaining == 8'd0) begin
            w_state_nxt = S_IDLE;
          end else begin
            w_index_nxt     = r_index + 1'b1;
            w_remaining_nxt = r_remaining - 8'd1;
          end
        end
      end
      S_READ: begin
        if (sb_end_transaction_i) begin
          w_state_nxt = S_IDLE;
        end else if (sb_busy_i) begin
          w_valid_nxt = 1'b1;
        end else if (r_remaining == 8'd0) begin
          w_state_nxt = S_END;
          w_end_nxt   = 1'b1;
        end else begin
          w_index_nxt     = r_index + 1'b1;
          w_remaining_nxt = r_remaining - 8'd1;
          w_valid_nxt     = 1'b1;
          w_load_rdata    = 1'b1;
        end
      end
      S_END:   w_state_nxt = S_IDLE;
      S_ERROR: w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge sb_clock_i or posedge sb_reset_i) begin
    if (sb_reset_i) begin
      r_state     <= S_IDLE;
      r_index     <= '0;
      r_remaining <= '0;
      r_be        <= '0;
      r_rdata     <= '0;
      r_valid     <= 1'b0;
      r_end       <= 1'b0;
      r_error     <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_index     <= w_index_nxt;
      r_remaining <= w_remaining_nxt;
      r_be        <= w_be_nxt;
      r_valid     <= w_valid_nxt;
      r_end       <= w_end_nxt;
      r_error     <= w_error_nxt;
      if (w_load_rdata)
        r_rdata <= r_mem[w_index_nxt];
      else if (!w_valid_nxt)
        r_rdata <= '0;
    end
  end

  // Scratchpad has no reset so it keeps its contents across a bus reset.
  always_ff @(posedge sb_clock_i) begin
    if (w_mem_we) begin
      for (int b = 0; b < 4; b++) begin
        if (r_be[b])
          r_mem[r_index][8*b +: 8] <= sb_address_data_i[8*b +: 8];
      end
    end
  end

  assign sb_address_data_o    = r_rdata;
  assign sb_data_valid_o      = r_valid;
  assign sb_end_transaction_o = r_end;
  assign sb_error_o           = r_error;
  assign sb_busy_o            = 1'b0;

endmodule
